dino_jump_ctrl: RTL and testbench



---
 rtl/dino_jump_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dino_jump_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_jump_ctrl.sv
// Vertical jump controller for the runner dino: synchronizes the buttons, derives one
// tick per video frame and steps a GROUND/RISE/FALL arc with gravity, jump cut and fast fall.
module dino_jump_ctrl #(
  parameter int GROUND_Y     = 275,
  parameter int X_POS        = 50,
  parameter int JUMP_V0      = 14,
  parameter int GRAVITY      = 1,
  parameter int FAST_GRAVITY = 3,
  parameter int JUMP_CUT     = 4,
  parameter int MAX_FALL     = 15,
  parameter int MIN_Y        = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up,
  input  logic        down,
  input  logic        screen_end,
  input  logic        game_on,
  input  logic        game_over,
  output logic [31:0] dino_x,
  output logic [31:0] dino_y,
  output logic        airborne,
  output logic        ducking,
  output logic [1:0]  state
);

  localparam logic [31:0] LP_GROUND_Y = 32'(GROUND_Y);
  localparam logic [31:0] LP_X_POS    = 32'(X_POS);
  localparam logic [31:0] LP_MIN_Y    = 32'(MIN_Y);
  localparam logic [7:0]  LP_V0       = 8'(JUMP_V0);
  localparam logic [7:0]  LP_GRAV     = 8'(GRAVITY);
  localparam logic [7:0]  LP_FAST     = 8'(FAST_GRAVITY);
  localparam logic [7:0]  LP_CUT      = 8'(JUMP_CUT);
  localparam logic [7:0]  LP_MAX_FALL = 8'(MAX_FALL);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_y, w_y_next;
  logic [7:0]  r_vel, w_vel_next;

  logic r_up_meta, r_up_s, r_up_prev, r_up_armed;
  logic r_dn_meta, r_dn_s;
  logic r_se_d1, r_se_d2, r_se_armed;
  logic [1:0] r_settle;
  logic r_jump_req;

  logic w_tick, w_up_edge, w_update;

  // r_settle marks when the synchronizer outputs carry real samples instead of reset
  // values; edges are only accepted once the input has been seen low after that, so a
  // button or screen_end held through reset cannot fake an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_up_meta  <= 1'b0;
      r_up_s     <= 1'b0;
      r_up_prev  <= 1'b0;
      r_up_armed <= 1'b0;
      r_dn_meta  <= 1'b0;
      r_dn_s     <= 1'b0;
      r_se_d1    <= 1'b0;
      r_se_d2    <= 1'b0;
      r_se_armed <= 1'b0;
      r_settle   <= 2'b00;
    end else begin
      r_up_meta  <= up;
      r_up_s     <= r_up_meta;
      r_up_prev  <= r_up_s;
      r_up_armed <= r_up_armed | (r_settle[1] & ~r_up_s);
      r_dn_meta  <= down;
      r_dn_s     <= r_dn_meta;
      r_se_d1    <= screen_end;
      r_se_d2    <= r_se_d1;
      r_se_armed <= r_se_armed | (r_settle[0] & ~r_se_d1);
      r_settle   <= {r_settle[0], 1'b1};
    end
  end

  assign w_tick    = r_se_d1 & ~r_se_d2 & r_se_armed;
  assign w_up_edge = r_up_s & ~r_up_prev & r_up_armed;
  assign w_update  = w_tick & game_on & ~game_over;

  // A press coinciding with a tick is kept so it is served on the following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_jump_req <= 1'b0;
    end else if (w_up_edge) begin
      r_jump_req <= 1'b1;
    end else if (w_tick) begin
      r_jump_req <= 1'b0;
    end
  end

  logic [31:0] w_vel32;
  logic [31:0] w_rise_y;
  logic [7:0]  w_rise_v;
  logic [7:0]  w_fall_g;
  logic [8:0]  w_fall_sum;
  logic [7:0]  w_fall_v;
  logic [31:0] w_fall_y;

  assign w_vel32    = {24'd0, r_vel};
  assign w_rise_y   = (r_y < LP_MIN_Y + w_vel32) ? LP_MIN_Y : (r_y - w_vel32);
  assign w_rise_v   = r_vel - LP_GRAV;
  assign w_fall_g   = r_dn_s ? LP_FAST : LP_GRAV;
  assign w_fall_sum = {1'b0, r_vel} + {1'b0, w_fall_g};
  assign w_fall_v   = (w_fall_sum > {1'b0, LP_MAX_FALL}) ? LP_MAX_FALL : w_fall_sum[7:0];
  assign w_fall_y   = r_y + {24'd0, w_fall_v};

  always_comb begin
    w_state_next = r_state;
    w_y_next     = r_y;
    w_vel_next   = r_vel;
    case (r_state)
      ST_GROUND: begin
        if (r_jump_req && !r_dn_s) begin
          w_state_next = ST_RISE;
          w_vel_next   = LP_V0;
        end
      end
      ST_RISE: begin
        if (r_dn_s) begin
          w_state_next = ST_FALL;
          w_vel_next   = 8'd0;
        end else begin
          w_y_next = w_rise_y;
          if (r_vel <= LP_GRAV) begin
            w_state_next = ST_FALL;
            w_vel_next   = 8'd0;
          end else if (!r_up_s && (w_rise_v > LP_CUT)) begin
            w_vel_next = LP_CUT;
          end else begin
            w_vel_next = w_rise_v;
          end
        end
      end
      ST_FALL: begin
        if (w_fall_y >= LP_GROUND_Y) begin
          w_state_next = ST_GROUND;
          w_y_next     = LP_GROUND_Y;
          w_vel_next   = 8'd0;
        end else begin
          w_y_next   = w_fall_y;
          w_vel_next = w_fall_v;
        end
      end
      default: begin
        w_state_next = ST_GROUND;
        w_y_next     = LP_GROUND_Y;
        w_vel_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_GROUND;
      r_y     <= LP_GROUND_Y;
      r_vel   <= 8'd0;
    end else if (w_update) begin
      r_state <= w_state_next;
      r_y     <= w_y_next;
      r_vel   <= w_vel_next;
    end
  end

  assign dino_x   = LP_X_POS;
  assign dino_y   = r_y;
  assign state    = r_state;
  assign airborne = (r_state != ST_GROUND);
  assign ducking  = r_dn_s & (r_state == ST_GROUND) & ~game_over;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed bench for dino_jump_ctrl; tick 0 is the frame that launches the jump,
// tick n the n-th frame spent airborne afterwards.
module tb_dino_jump_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        up = 1'b0;
  logic        down = 1'b0;
  logic        screen_end = 1'b0;
  logic        game_on = 1'b1;
  logic        game_over = 1'b0;
  logic [31:0] dino_x;
  logic [31:0] dino_y;
  logic        airborne;
  logic        ducking;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_mis = 0;

  dino_jump_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .up         (up),
    .down       (down),
    .screen_end (screen_end),
    .game_on    (game_on),
    .game_over  (game_over),
    .dino_x     (dino_x),
    .dino_y     (dino_y),
    .airborne   (airborne),
    .ducking    (ducking),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    screen_end = 1'b1;
    clocks(4);
    screen_end = 1'b0;
    clocks(4);
  endtask

  task automatic do_reset();
    up = 1'b0; down = 1'b0; screen_end = 1'b0; game_on = 1'b1; game_over = 1'b0;
    reset = 1'b1;
    clocks(2);
    reset = 1'b0;
    clocks(4);
  endtask

  // Press up and give the synchronizer time to register the request.
  task automatic press_up();
    up = 1'b1;
    clocks(5);
  endtask

  task automatic test_reset();
    screen_end = 1'b1;
    reset = 1'b1;
    clocks(3);
    n_cmp++; if (dino_y !== 32'd275) begin n_mis++; $display("FAIL reset_y got %0d want 275", dino_y); end
    n_cmp++; if (state !== 2'd0) begin n_mis++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (dino_x !== 32'd50) begin n_mis++; $display("FAIL reset_x got %0d want 50", dino_x); end
    n_cmp++; if (airborne !== 1'b0 || ducking !== 1'b0) begin n_mis++; $display("FAIL reset_flags got air=%b duck=%b want 0 0", airborne, ducking); end
    // screen_end still high at release: no tick until it falls and rises again
    reset = 1'b0;
    clocks(2);
    press_up();
    clocks(6);
    n_cmp++; if (state !== 2'd0) begin n_mis++; $display("FAIL no_stale_tick got state %0d want 0", state); end
    screen_end = 1'b0;
    clocks(4);
    frame();
    n_cmp++; if (state !== 2'd1 || airborne !== 1'b1) begin n_mis++; $display("FAIL first_tick_launch got state %0d air %b want 1 1", state, airborne); end
    do_reset();
  endtask

  task automatic test_full_jump();
    press_up();
    frame();
    n_cmp++; if (state !== 2'd1 || dino_y !== 32'd275) begin n_mis++; $display("FAIL full_t0 got state %0d y %0d want 1 275", state, dino_y); end
    for (int t = 1; t <= 28; t++) begin
      frame();
      case (t)
        1:  begin n_cmp++; if (dino_y !== 32'd261) begin n_mis++; $display("FAIL full_t1 y got %0d want 261", dino_y); end end
        2:  begin n_cmp++; if (dino_y !== 32'd248) begin n_mis++; $display("FAIL full_t2 y got %0d want 248", dino_y); end end
        13: begin n_cmp++; if (dino_y !== 32'd171 || state !== 2'd1) begin n_mis++; $display("FAIL full_t13 got y %0d state %0d want 171 1", dino_y, state); end end
        14: begin n_cmp++; if (dino_y !== 32'd170 || state !== 2'd2) begin n_mis++; $display("FAIL full_apex got y %0d state %0d want 170 2", dino_y, state); end end
        27: begin n_cmp++; if (dino_y !== 32'd261 || state !== 2'd2) begin n_mis++; $display("FAIL full_t27 got y %0d state %0d want 261 2", dino_y, state); end end
        28: begin n_cmp++; if (dino_y !== 32'd275 || state !== 2'd0) begin n_mis++; $display("FAIL full_land got y %0d state %0d want 275 0", dino_y, state); end end
        default: ;
      endcase
    end
    up = 1'b0;
    clocks(4);
  endtask

  task automatic test_short_hop();
    int exp_y[1:5] = '{261, 248, 236, 225, 221};
    int min_y;
    press_up();
    frame();
    for (int t = 1; t <= 5; t++) begin
      if (t == 4) begin
        up = 1'b0;
        clocks(4);
      end
      frame();
      n_cmp++; if (dino_y !== 32'(exp_y[t])) begin n_mis++; $display("FAIL hop_t%0d y got %0d want %0d", t, dino_y, exp_y[t]); end
    end
    min_y = 275;
    for (int t = 6; t <= 19; t++) begin
      frame();
      if (int'(dino_y) < min_y) min_y = int'(dino_y);
      if (t == 18) begin
        n_cmp++; if (dino_y !== 32'd270 || state !== 2'd2) begin n_mis++; $display("FAIL hop_t18 got y %0d state %0d want 270 2", dino_y, state); end
      end
    end
    n_cmp++; if (min_y != 215) begin n_mis++; $display("FAIL hop_apex got %0d want 215", min_y); end
    n_cmp++; if (dino_y !== 32'd275 || state !== 2'd0) begin n_mis++; $display("FAIL hop_land got y %0d state %0d want 275 0", dino_y, state); end
  endtask

  task automatic test_duck();
    int exp_y[1:3] = '{264, 270, 275};
    down = 1'b1;
    clocks(4);
    press_up();
    frame();
    n_cmp++; if (state !== 2'd0 || ducking !== 1'b1 || dino_y !== 32'd275) begin n_mis++; $display("FAIL duck_ground got state %0d duck %b y %0d want 0 1 275", state, ducking, dino_y); end
    up = 1'b0; down = 1'b0;
    clocks(4);
    n_cmp++; if (ducking !== 1'b0) begin n_mis++; $display("FAIL duck_release got %b want 0", ducking); end
    press_up();
    frame();
    frame();
    n_cmp++; if (dino_y !== 32'd261) begin n_mis++; $display("FAIL duckrise_t1 y got %0d want 261", dino_y); end
    down = 1'b1;
    clocks(4);
    frame();
    n_cmp++; if (state !== 2'd2 || dino_y !== 32'd261 || ducking !== 1'b0) begin n_mis++; $display("FAIL duck_cut got state %0d y %0d duck %b want 2 261 0", state, dino_y, ducking); end
    for (int k = 1; k <= 3; k++) begin
      frame();
      n_cmp++; if (dino_y !== 32'(exp_y[k])) begin n_mis++; $display("FAIL fastfall_%0d y got %0d want %0d", k, dino_y, exp_y[k]); end
    end
    n_cmp++; if (state !== 2'd0 || ducking !== 1'b1) begin n_mis++; $display("FAIL fastfall_land got state %0d duck %b want 0 1", state, ducking); end
    up = 1'b0; down = 1'b0;
    clocks(4);
  endtask

  task automatic test_freeze();
    press_up();
    frame();
    repeat (5) frame();
    n_cmp++; if (dino_y !== 32'd215) begin n_mis++; $display("FAIL freeze_t5 y got %0d want 215", dino_y); end
    game_over = 1'b1;
    down = 1'b1;
    clocks(4);
    for (int f = 1; f <= 20; f++) begin
      frame();
      n_cmp++; if (dino_y !== 32'd215 || state !== 2'd1 || ducking !== 1'b0) begin n_mis++; $display("FAIL freeze_f%0d got y %0d state %0d duck %b want 215 1 0", f, dino_y, state, ducking); end
    end
    do_reset();
    game_on = 1'b0;
    press_up();
    repeat (3) frame();
    n_cmp++; if (dino_y !== 32'd275 || state !== 2'd0) begin n_mis++; $display("FAIL game_off got y %0d state %0d want 275 0", dino_y, state); end
    game_on = 1'b1;
    frame();
    n_cmp++; if (state !== 2'd0) begin n_mis++; $display("FAIL game_off_stale got state %0d want 0", state); end
    up = 1'b0;
    clocks(4);
  endtask

  task automatic test_reset_mid_jump();
    press_up();
    frame();
    repeat (10) frame();
    n_cmp++; if (dino_y !== 32'd180) begin n_mis++; $display("FAIL mid_t10 y got %0d want 180", dino_y); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (dino_y !== 32'd275 || state !== 2'd0) begin n_mis++; $display("FAIL async_reset got y %0d state %0d want 275 0", dino_y, state); end
    clocks(2);
    reset = 1'b0;
    clocks(6);
    repeat (3) frame();
    n_cmp++; if (state !== 2'd0 || dino_y !== 32'd275) begin n_mis++; $display("FAIL held_up got state %0d y %0d want 0 275", state, dino_y); end
    up = 1'b0;
    clocks(5);
    press_up();
    frame();
    n_cmp++; if (state !== 2'd1) begin n_mis++; $display("FAIL repress got state %0d want 1", state); end
    frame();
    n_cmp++; if (dino_y !== 32'd261) begin n_mis++; $display("FAIL repress_t1 y got %0d want 261", dino_y); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    press_up();
    frame();
    repeat (20) frame();
    up = 1'b0;
    clocks(4);
    press_up();
    repeat (8) frame();
    n_cmp++; if (dino_y !== 32'd275 || state !== 2'd0) begin n_mis++; $display("FAIL b2b_land got y %0d state %0d want 275 0", dino_y, state); end
    frame();
    n_cmp++; if (state !== 2'd0) begin n_mis++; $display("FAIL no_buffered_jump got state %0d want 0", state); end
    up = 1'b0;
    clocks(4);
    press_up();
    frame();
    n_cmp++; if (state !== 2'd1) begin n_mis++; $display("FAIL b2b_relaunch got state %0d want 1", state); end
    up = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_full_jump();
    test_short_hop();
    test_duck();
    test_freeze();
    test_reset_mid_jump();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired after %0d compares", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
